// File: rtl/iir_pkg.sv
// Shared types and fixed-point helpers for the time-multiplexed IIR section.
// The helpers work on a wide signed word so callers never lose intermediate bits.
package iir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL_A,
        MUL_B0,
        MUL_B1,
        OUT
    } state_t;

    localparam int WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Round half up, then arithmetic shift right by frac_bits.
    function automatic wide_t rnd_shift(input wide_t p, input int frac_bits);
        wide_t half;
        half = wide_t'(1) <<< (frac_bits - 1);
        return (p + half) >>> frac_bits;
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                      input int n_bits, output logic clipped);
        wide_t sum;
        wide_t hi;
        wide_t lo;
        wide_t res;
        sum     = a + b;
        hi      = (wide_t'(1) <<< (n_bits - 1)) - wide_t'(1);
        lo      = -hi - wide_t'(1);
        clipped = 1'b0;
        res     = sum;
        if (sum > hi) begin
            res     = hi;
            clipped = 1'b1;
        end else if (sum < lo) begin
            res     = lo;
            clipped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fixed_mult_rnd.sv
// Shared signed multiplier: p_full = addend +/- rnd(a*b) at full precision,
// p = the same value clamped to N_BITS, sat = clamp happened.
module fixed_mult_rnd
    import iir_pkg::*;
#(
    parameter int N_BITS    = 32,
    parameter int FRAC_BITS = 16,
    parameter int AW        = 2 * N_BITS + 2
) (
    input  logic signed [N_BITS-1:0] a,
    input  logic signed [N_BITS-1:0] b,
    input  logic signed [AW-1:0]     addend,
    input  logic                     sub,
    output logic signed [AW-1:0]     p_full,
    output logic signed [N_BITS-1:0] p,
    output logic                     sat
);

    logic signed [2*N_BITS-1:0] prod;
    wide_t                      prod_rnd;
    wide_t                      sum;
    logic                       clip;

    always_comb begin
        clip     = 1'b0;
        prod     = (2*N_BITS)'(a) * (2*N_BITS)'(b);
        prod_rnd = rnd_shift(wide_t'(prod), FRAC_BITS);
        sum      = sub ? (wide_t'(addend) - prod_rnd) : (wide_t'(addend) + prod_rnd);
        p        = N_BITS'(sat_add(sum, '0, N_BITS, clip));
        p_full   = AW'(sum);
        sat      = clip;
    end

endmodule

// File: rtl/iir_tdm.sv
// Multi-channel first-order IIR sharing one multiplier across three FSM steps.
// state  | meaning
// IDLE   | ready for a sample; latch x, ch, coefficients and xo = sat(x+offset)
// MUL_A  | w0 = sat(xo - rnd(a*w1[ch]))
// MUL_B0 | acc = rnd(b0*w0), kept at full precision
// MUL_B1 | y = sat(acc + rnd(b1*w1[ch])); w1[ch] <= w0
// OUT    | hold result until out_ready_i
module iir_tdm
    import iir_pkg::*;
#(
    parameter int  N_BITS    = 32,
    parameter int  FRAC_BITS = 16,
    parameter int  CHANNELS  = 4,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [N_BITS-1:0] x_i,
    input  logic        [CH_W-1:0]   ch_i,
    input  logic signed [N_BITS-1:0] b0_i,
    input  logic signed [N_BITS-1:0] b1_i,
    input  logic signed [N_BITS-1:0] a_i,
    input  logic signed [N_BITS-1:0] offset_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [N_BITS-1:0] y_o,
    output logic        [CH_W-1:0]   ch_o,
    output logic                     sat_o
);

    localparam int AW = 2 * N_BITS + 2;

    state_t                    state;
    logic signed [N_BITS-1:0]  w1 [CHANNELS];
    logic signed [N_BITS-1:0]  xo_q, w0_q, a_q, b0_q, b1_q;
    logic signed [N_BITS-1:0]  xo_next, w1_cur;
    logic signed [AW-1:0]      acc_q;
    logic        [CH_W-1:0]    ch_q;
    logic                      ch_ok_q, ch_ok_in, sat_q, xo_sat;

    logic signed [N_BITS-1:0]  m_a, m_b, m_p;
    logic signed [AW-1:0]      m_addend, m_full;
    logic                      m_sub, m_sat;

    assign ch_ok_in = int'(ch_i) < CHANNELS;

    always_comb begin
        xo_sat  = 1'b0;
        xo_next = N_BITS'(sat_add(wide_t'(x_i), wide_t'(offset_i), N_BITS, xo_sat));
    end

    // Out-of-range channels read as zero state and never write back.
    always_comb begin
        w1_cur = '0;
        if (ch_ok_q) w1_cur = w1[ch_q];
    end

    always_comb begin
        m_a      = b0_q;
        m_b      = w0_q;
        m_addend = '0;
        m_sub    = 1'b0;
        case (state)
            MUL_A: begin
                m_a      = a_q;
                m_b      = w1_cur;
                m_addend = AW'(xo_q);
                m_sub    = 1'b1;
            end
            MUL_B1: begin
                m_a      = b1_q;
                m_b      = w1_cur;
                m_addend = acc_q;
            end
            default: ;
        endcase
    end

    fixed_mult_rnd #(
        .N_BITS   (N_BITS),
        .FRAC_BITS(FRAC_BITS),
        .AW       (AW)
    ) u_mult (
        .a     (m_a),
        .b     (m_b),
        .addend(m_addend),
        .sub   (m_sub),
        .p_full(m_full),
        .p     (m_p),
        .sat   (m_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            y_o         <= '0;
            ch_o        <= '0;
            sat_o       <= 1'b0;
            xo_q        <= '0;
            w0_q        <= '0;
            a_q         <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            acc_q       <= '0;
            ch_q        <= '0;
            ch_ok_q     <= 1'b0;
            sat_q       <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) w1[i] <= '0;
        end else if (clear_i) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) w1[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_o <= 1'b1;
                    if (in_valid_i && in_ready_o) begin
                        xo_q       <= xo_next;
                        sat_q      <= xo_sat;
                        a_q        <= a_i;
                        b0_q       <= b0_i;
                        b1_q       <= b1_i;
                        ch_q       <= ch_i;
                        ch_ok_q    <= ch_ok_in;
                        in_ready_o <= 1'b0;
                        state      <= MUL_A;
                    end
                end
                MUL_A: begin
                    w0_q  <= m_p;
                    sat_q <= sat_q | m_sat;
                    state <= MUL_B0;
                end
                MUL_B0: begin
                    acc_q <= m_full;
                    state <= MUL_B1;
                end
                MUL_B1: begin
                    if (ch_ok_q) begin
                        y_o      <= m_p;
                        sat_o    <= sat_q | m_sat;
                        w1[ch_q] <= w0_q;
                    end else begin
                        y_o   <= '0;
                        sat_o <= 1'b0;
                    end
                    ch_o        <= ch_q;
                    out_valid_o <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_tdm.sv
// Scoreboard bench for iir_tdm: a spec-level reference model computes each
// expected result at input acceptance; a monitor compares at output handshake.
module tb_iir_tdm;

    localparam int NB = 32;
    localparam int FB = 16;
    localparam int CH = 3;
    localparam int CW = 2;
    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] HALF = 32'h0000_8000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          out_ready_i = 1'b1;
    logic          in_ready_o, out_valid_o, sat_o;
    logic [31:0]   x_i = '0, b0_i = '0, b1_i = '0, a_i = '0, offset_i = '0;
    logic [31:0]   y_o;
    logic [CW-1:0] ch_i = '0, ch_o;

    typedef struct {
        logic [31:0]   y;
        logic [CW-1:0] ch;
        logic          sat;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    longint mw1[4];
    int     vectors = 0;
    int     miscompares = 0;
    string  phase = "init";

    iir_tdm #(.N_BITS(NB), .FRAC_BITS(FB), .CHANNELS(CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .x_i        (x_i),
        .ch_i       (ch_i),
        .b0_i       (b0_i),
        .b1_i       (b1_i),
        .a_i        (a_i),
        .offset_i   (offset_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .y_o        (y_o),
        .ch_o       (ch_o),
        .sat_o      (sat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint rnd(input longint p);
        return (p + 64'sd32768) >>> 16;
    endfunction

    function automatic longint sat(input longint v, inout bit s);
        if (v > 64'sd2147483647) begin
            s = 1'b1;
            return 64'sd2147483647;
        end
        if (v < -64'sd2147483648) begin
            s = 1'b1;
            return -64'sd2147483648;
        end
        return v;
    endfunction

    task automatic model(input logic [31:0] x, input logic [CW-1:0] ch, output exp_t e);
        bit     s;
        longint xo, w0, acc, y;
        s    = 1'b0;
        e.ch = ch;
        if (int'(ch) >= CH) begin
            e.y   = '0;
            e.sat = 1'b0;
        end else begin
            xo  = sat(longint'($signed(x)) + longint'($signed(offset_i)), s);
            w0  = sat(xo - rnd(longint'($signed(a_i)) * mw1[ch]), s);
            acc = rnd(longint'($signed(b0_i)) * w0);
            y   = sat(acc + rnd(longint'($signed(b1_i)) * mw1[ch]), s);
            mw1[ch] = w0;
            e.y   = y[31:0];
            e.sat = s;
        end
    endtask

    task automatic mclear();
        foreach (mw1[i]) mw1[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_coef(input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] a, input logic [31:0] off);
        b0_i = b0; b1_i = b1; a_i = a; offset_i = off;
    endtask

    task automatic send(input logic [31:0] x, input logic [CW-1:0] ch, input bit push);
        bit   taken;
        exp_t e;
        taken      = 1'b0;
        x_i        = x;
        ch_i       = ch;
        in_valid_i = 1'b1;
        for (int n = 0; n < 50 && !taken; n++) begin
            taken = in_ready_o;
            tick();
        end
        in_valid_i = 1'b0;
        if (!taken) chk({phase, ".send_timeout"}, 64'd0, 64'd1);
        else if (push) begin
            model(x, ch, e);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (sb.size() != 0 || out_valid_o); n++) tick();
        chk({phase, ".drain"}, sb.size(), 0);
        tick();
    endtask

    task automatic expect_silence(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (8) begin
            if (out_valid_o) seen = 1'b1;
            tick();
        end
        chk(tag, seen, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) chk({phase, ".unexpected_out"}, out_valid_o, 0);
            else begin
                mon_e = sb.pop_front();
                chk({phase, ".y"},   y_o,   mon_e.y);
                chk({phase, ".ch"},  ch_o,  mon_e.ch);
                chk({phase, ".sat"}, sat_o, mon_e.sat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1);
    end

    initial begin
        int lat;
        mclear();

        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", in_ready_o, 0);
        chk("reset.out_valid", out_valid_o, 0);
        chk("reset.y", y_o, 0);
        chk("reset.ch", ch_o, 0);
        chk("reset.sat", sat_o, 0);
        rst_n = 1'b1;
        tick();
        chk("reset.ready_after", in_ready_o, 1);

        phase = "pass";
        set_coef(ONE, 0, 0, 0);
        send(32'h0003_0000, 0, 1);
        chk("pass.busy_ready", in_ready_o, 0);
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk("pass.latency", lat, 4);
        drain();

        phase = "rec";
        set_coef(ONE, 0, 32'hFFFF_8000, 0);
        send(ONE, 1, 1);
        send(0, 1, 1);
        send(0, 1, 1);
        drain();

        phase = "iso";
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        mclear();
        set_coef(HALF, HALF, 0, 0);
        send(32'h0002_0000, 0, 1);
        send(0, 2, 1);
        send(32'h0002_0000, 0, 1);
        send(0, 2, 1);
        drain();

        phase = "sat";
        set_coef(ONE, 0, 0, 32'h0002_0000);
        send(32'h7FFF_0000, 0, 1);
        set_coef(ONE, 0, 0, 32'hFFFF_0000);
        send(32'h8000_0000, 0, 1);
        drain();

        phase = "oor";
        set_coef(ONE, ONE, 0, 0);
        send(ONE, 3, 1);
        send(ONE, 2, 1);
        drain();

        phase = "bp";
        out_ready_i = 1'b0;
        set_coef(ONE, 0, 0, 0);
        send(32'h0005_0000, 2, 1);
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp.valid", out_valid_o, 1);
        x_i = 32'h0006_0000;
        ch_i = 2;
        in_valid_i = 1'b1;
        repeat (3) begin
            tick();
            chk("bp.hold_y", y_o, sb[0].y);
            chk("bp.hold_ch", ch_o, sb[0].ch);
            chk("bp.hold_sat", sat_o, sb[0].sat);
            chk("bp.hold_ready", in_ready_o, 0);
            chk("bp.hold_valid", out_valid_o, 1);
        end
        out_ready_i = 1'b1;
        tick();
        chk("bp.valid_drop", out_valid_o, 0);
        chk("bp.ready_after", in_ready_o, 1);
        begin
            exp_t e;
            model(32'h0006_0000, 2, e);
            sb.push_back(e);
        end
        tick();
        in_valid_i = 1'b0;
        chk("bp.taken", in_ready_o, 0);
        drain();

        phase = "clr";
        set_coef(ONE, 0, 32'hFFFF_8000, 0);
        send(ONE, 1, 1);
        send(0, 1, 1);
        drain();
        send(0, 1, 0);
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        mclear();
        expect_silence("clr.no_out");
        send(ONE, 1, 1);
        drain();

        phase = "rst";
        send(0, 1, 1);
        drain();
        send(0, 1, 0);
        tick();
        rst_n = 1'b0;
        #2;
        chk("rst.out_valid", out_valid_o, 0);
        chk("rst.in_ready", in_ready_o, 0);
        tick();
        rst_n = 1'b1;
        mclear();
        expect_silence("rst.no_out");
        send(ONE, 1, 1);
        drain();

        phase = "rnd";
        for (int i = 0; i < 12; i++) begin
            set_coef($urandom, $urandom, $urandom, $urandom);
            send($urandom, CW'($urandom_range(0, 3)), 1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
